// File: rtl/entropy_sel_pkg.sv
// Shared constants for the entropy source selector.
// Source count, selector width and fixed source indices.
package entropy_sel_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    localparam logic [SEL_W-1:0] SRC_RO   = 2'd0;
    localparam logic [SEL_W-1:0] SRC_ALT  = 2'd1;
    localparam logic [SEL_W-1:0] SRC_REP  = 2'd2;
    localparam logic [SEL_W-1:0] SRC_USER = 2'd3;

endpackage

// File: rtl/entropy_source_select_if.sv
// Bus bundle for entropy_source_select.
// master: drives src_bit/src_valid/sel; slave: drives bit_out/valid_out/sel_changed/alt_bit.
interface entropy_source_select_if;
    import entropy_sel_pkg::*;

    logic [NUM_SRC-1:0] src_bit;
    logic [NUM_SRC-1:0] src_valid;
    logic [SEL_W-1:0]   sel;
    logic               bit_out;
    logic               valid_out;
    logic               sel_changed;
    logic               alt_bit;

    modport master (
        output src_bit, src_valid, sel,
        input  bit_out, valid_out, sel_changed, alt_bit
    );

    modport slave (
        input  src_bit, src_valid, sel,
        output bit_out, valid_out, sel_changed, alt_bit
    );

endinterface

// File: rtl/sel_change_detect.sv
// Selector change detector: registers sel and pulses o_changed for one
// cycle per change. Ports: clk, rst (async high), i_sel, o_changed.
module sel_change_detect
    import entropy_sel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_changed
);

    logic [SEL_W-1:0] r_sel_q;
    logic             r_primed;
    logic             r_pulse;

    // First edge after reset only captures sel, so a non-zero sel held
    // through reset does not look like a change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_q  <= '0;
            r_primed <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_sel_q  <= i_sel;
            r_primed <= 1'b1;
            r_pulse  <= r_primed && (i_sel != r_sel_q);
        end
    end

    assign o_changed = r_pulse;

endmodule

// File: rtl/entropy_source_select.sv
// Entropy source selector: 4:1 combinational mux with valid blanking after
// selector changes. Ports: clk, rst (async high), bus (slave modport).
// Macro ALT_RNG_EN: internal alternating generator replaces source 1.
module entropy_source_select
    import entropy_sel_pkg::*;
#(
    parameter logic ALT_INIT = 1'b0
)(
    input  logic                    clk,
    input  logic                    rst,
    entropy_source_select_if.slave  bus
);

    logic [NUM_SRC-1:0] w_bit;
    logic [NUM_SRC-1:0] w_vld;
    logic               w_bit_sel;
    logic               w_pre_valid;
    logic               w_changed;

`ifdef ALT_RNG_EN
    logic r_alt_bit;
    logic r_alt_valid;
    logic [1:0] w_unused_src1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alt_bit   <= ALT_INIT;
            r_alt_valid <= 1'b0;
        end else begin
            r_alt_bit   <= ~r_alt_bit;
            r_alt_valid <= 1'b1;
        end
    end

    assign w_unused_src1 = {bus.src_bit[SRC_ALT], bus.src_valid[SRC_ALT]};

    assign w_bit = {bus.src_bit[SRC_USER], bus.src_bit[SRC_REP],
                    r_alt_bit, bus.src_bit[SRC_RO]};
    assign w_vld = {bus.src_valid[SRC_USER], bus.src_valid[SRC_REP],
                    r_alt_valid, bus.src_valid[SRC_RO]};
    assign bus.alt_bit = r_alt_bit;
`else
    logic w_unused_init;

    assign w_unused_init = ALT_INIT;
    assign w_bit         = bus.src_bit;
    assign w_vld         = bus.src_valid;
    assign bus.alt_bit   = 1'b0;
`endif

    always_comb begin
        w_bit_sel   = 1'b0;
        w_pre_valid = 1'b0;
        unique case (bus.sel)
            SRC_RO:   begin w_bit_sel = w_bit[0]; w_pre_valid = w_vld[0]; end
            SRC_ALT:  begin w_bit_sel = w_bit[1]; w_pre_valid = w_vld[1]; end
            SRC_REP:  begin w_bit_sel = w_bit[2]; w_pre_valid = w_vld[2]; end
            SRC_USER: begin w_bit_sel = w_bit[3]; w_pre_valid = w_vld[3]; end
            default:  begin w_bit_sel = 1'b0;     w_pre_valid = 1'b0;     end
        endcase
    end

    sel_change_detect u_det (
        .clk       (clk),
        .rst       (rst),
        .i_sel     (bus.sel),
        .o_changed (w_changed)
    );

    assign bus.bit_out     = w_bit_sel;
    assign bus.valid_out   = w_pre_valid & ~w_changed;
    assign bus.sel_changed = w_changed;

endmodule

// File: tb/tb_entropy_source_select.sv
// Directed testbench for entropy_source_select.
// Works with ALT_RNG_EN defined or undefined.
module tb_entropy_source_select;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    entropy_source_select_if bus ();

    entropy_source_select #(.ALT_INIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sel = 2'd3;
        bus.src_bit = 4'b1010;
        bus.src_valid = 4'b1111;
        #2;
        n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL rst_chg got %b exp 0", bus.sel_changed); end
        n_vec++; if (bus.alt_bit !== 1'b0) begin n_err++; $display("FAIL rst_alt got %b exp 0", bus.alt_bit); end
        n_vec++; if (bus.bit_out !== 1'b1) begin n_err++; $display("FAIL rst_bit got %b exp 1", bus.bit_out); end
        n_vec++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL rst_vld got %b exp 1", bus.valid_out); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL prime_chg edge %0d got %b exp 0", i, bus.sel_changed); end
        end
    endtask

    // Combinational sweep while held in reset: generator is at ALT_INIT
    // with alt_valid low, detector cleared.
    task automatic test_mux();
        logic [3:0] bits [2];
        logic [3:0] vlds [2];
        logic eb;
        logic ev;
        bits[0] = 4'b1010; vlds[0] = 4'b1111;
        bits[1] = 4'b0101; vlds[1] = 4'b0110;
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            bus.src_bit = bits[p];
            bus.src_valid = vlds[p];
            for (int s = 0; s < 4; s++) begin
                bus.sel = 2'(s);
                eb = bits[p][s];
                ev = vlds[p][s];
`ifdef ALT_RNG_EN
                if (s == 1) begin eb = 1'b0; ev = 1'b0; end
`endif
                #1;
                n_vec++; if (bus.bit_out !== eb) begin n_err++; $display("FAIL mux_bit p%0d s%0d got %b exp %b", p, s, bus.bit_out, eb); end
                n_vec++; if (bus.valid_out !== ev) begin n_err++; $display("FAIL mux_vld p%0d s%0d got %b exp %b", p, s, bus.valid_out, ev); end
            end
        end
        tick();
        rst = 1'b0;
        bus.src_bit = 4'b1010;
        bus.src_valid = 4'b1111;
        tick();
    endtask

    task automatic test_change();
        bus.sel = 2'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i >= 1) begin
                n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL hold_chg %0d got %b exp 0", i, bus.sel_changed); end
                n_vec++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL hold_vld %0d got %b exp 1", i, bus.valid_out); end
            end
        end
        bus.sel = 2'd3;
        #1;
        n_vec++; if (bus.bit_out !== 1'b1) begin n_err++; $display("FAIL chg_bit got %b exp 1", bus.bit_out); end
        n_vec++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL pre_edge_vld got %b exp 1", bus.valid_out); end
        tick();
        n_vec++; if (bus.sel_changed !== 1'b1) begin n_err++; $display("FAIL chg_pulse got %b exp 1", bus.sel_changed); end
        n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL chg_blank got %b exp 0", bus.valid_out); end
        tick();
        n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL chg_end got %b exp 0", bus.sel_changed); end
        n_vec++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL chg_vld_back got %b exp 1", bus.valid_out); end
    endtask

    task automatic test_back_to_back();
        bus.sel = 2'd0;
        tick();
        tick();
        n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b exp 0", bus.sel_changed); end
        bus.sel = 2'd1;
        tick();
        n_vec++; if (bus.sel_changed !== 1'b1) begin n_err++; $display("FAIL b2b_first got %b exp 1", bus.sel_changed); end
        bus.sel = 2'd2;
        tick();
        n_vec++; if (bus.sel_changed !== 1'b1) begin n_err++; $display("FAIL b2b_second got %b exp 1", bus.sel_changed); end
        n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_blank got %b exp 0", bus.valid_out); end
        tick();
        n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b exp 0", bus.sel_changed); end
    endtask

    task automatic test_glitch();
        bus.sel = 2'd2;
        tick();
        tick();
        bus.sel = 2'd3;
        #2;
        bus.sel = 2'd2;
        tick();
        n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL glitch_chg got %b exp 0", bus.sel_changed); end
    endtask

    task automatic test_alternation();
        logic [5:0] exp_seq;
        exp_seq = 6'b101010;
        rst = 1'b1;
        bus.sel = 2'd1;
        bus.src_bit = 4'b0000;
        bus.src_valid = 4'b1111;
        tick();
        rst = 1'b0;
        #1;
`ifdef ALT_RNG_EN
        n_vec++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL alt_pre_vld got %b exp 0", bus.valid_out); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++; if (bus.bit_out !== exp_seq[5-i]) begin n_err++; $display("FAIL alt_bit edge %0d got %b exp %b", i+1, bus.bit_out, exp_seq[5-i]); end
            n_vec++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL alt_vld edge %0d got %b exp 1", i+1, bus.valid_out); end
        end
`else
        for (int i = 0; i < 6; i++) begin
            bus.src_bit = {2'b00, exp_seq[5-i], 1'b0};
            tick();
            n_vec++; if (bus.bit_out !== exp_seq[5-i]) begin n_err++; $display("FAIL ext1_bit edge %0d got %b exp %b", i+1, bus.bit_out, exp_seq[5-i]); end
            n_vec++; if (bus.alt_bit !== 1'b0) begin n_err++; $display("FAIL alt_tied edge %0d got %b exp 0", i+1, bus.alt_bit); end
        end
`endif
    endtask

    task automatic test_reset_mid();
        bus.sel = 2'd0;
        tick();
        tick();
        bus.sel = 2'd3;
        tick();
        n_vec++; if (bus.sel_changed !== 1'b1) begin n_err++; $display("FAIL mid_pulse got %b exp 1", bus.sel_changed); end
        rst = 1'b1;
        #1;
        n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL mid_rst_chg got %b exp 0", bus.sel_changed); end
        n_vec++; if (bus.alt_bit !== 1'b0) begin n_err++; $display("FAIL mid_rst_alt got %b exp 0", bus.alt_bit); end
        tick();
        rst = 1'b0;
        tick();
        n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL post_rst_e1 got %b exp 0", bus.sel_changed); end
        tick();
        n_vec++; if (bus.sel_changed !== 1'b0) begin n_err++; $display("FAIL post_rst_e2 got %b exp 0", bus.sel_changed); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.sel = '0;
        bus.src_bit = '0;
        bus.src_valid = '0;
        test_reset();
        test_mux();
        test_change();
        test_back_to_back();
        test_glitch();
        test_alternation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/entropy_source_select.md
ENTROPY_SOURCE_SELECT -- requirements
Module: entropy_source_select

Interface
REQ-001 SHALL have parameter ALT_INIT, default 1'b0: value loaded into the alternating generator on reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port src_bit, input, 4: external entropy bits, index = source number.
REQ-005 SHALL have port src_valid, input, 4: per-source valid flags, same indexing.
REQ-006 SHALL have port sel, input, 2: source selector (0 ring osc, 1 alternating, 2 repeating, 3 user).
REQ-007 SHALL have port bit_out, output, 1: selected entropy bit.
REQ-008 SHALL have port valid_out, output, 1: selected valid, blanked on selector change.
REQ-009 SHALL have port sel_changed, output, 1: one-cycle pulse after sel changes.
REQ-010 SHALL have port alt_bit, output, 1: alternating-generator state, for observation.

Function
REQ-011 The alternating generator SHALL toggle alt_bit on every rising clk edge while rst is low.
- alt_valid is internal: 0 in reset, 1 from the first edge after rst falls.
REQ-012 With ALT_RNG_EN defined, source 1 SHALL be {alt_bit, alt_valid}, and src_bit[1]/src_valid[1] SHALL be ignored.
REQ-013 Source mux SHALL be purely combinational, zero latency:
- bit_out = source[sel] bit.
- pre-valid = source[sel] valid.
- no glitch filtering.
REQ-014 Change detector SHALL register sel into sel_q on every edge.
- On each edge, sel_changed <= (sel != sel_q), so the pulse lasts exactly one cycle per change.
- Changes on consecutive cycles SHALL keep sel_changed high for each of those cycles.
REQ-015 The first edge after reset SHALL only load sel_q (primed flag set) and SHALL NOT raise sel_changed, whatever the value of sel.
REQ-016 valid_out SHALL equal pre-valid AND NOT sel_changed: one cycle of blanking after each selector change.
REQ-017 A sel change that returns to the previous value before the next edge SHALL NOT be detected.

Reset
REQ-018 While rst is high:
- alt_bit = ALT_INIT, alt_valid = 0.
- sel_q = 0, primed = 0.
- sel_changed = 0.
- bit_out/valid_out follow the mux, so valid_out = 0 when sel = 1 and ALT_RNG_EN is defined.
REQ-019 Asserting rst mid-operation SHALL clear all state immediately (asynchronous), with no pending pulse after release.

Configuration
REQ-020 Macro ALT_RNG_EN SHALL control the internal alternating generator:
- Defined: generator instantiated; drives source 1 and alt_bit.
- Undefined: no generator flops; source 1 taken from src_bit[1]/src_valid[1]; alt_bit tied to 0.

Structure
REQ-021 Shared package entropy_sel_pkg SHALL hold:
- NUM_SRC = 4.
- SEL_W = 2.
- source indices SRC_RO = 0, SRC_ALT = 1, SRC_REP = 2, SRC_USER = 3.
REQ-022 The change detector (sel_q, primed, pulse) SHALL be one sub-module, sel_change_detect.
- Generator and mux stay inline in entropy_source_select.

Verification
REQ-023 Alternation: ALT_RNG_EN defined, ALT_INIT=0, sel=1, release rst, run 6 edges -> bit_out 1,0,1,0,1,0 after successive edges; valid_out=1 from edge 1.
REQ-024 Mux: ALT_RNG_EN undefined, src_bit=4'b1010, src_valid=4'b1111, sel swept 0..3 -> bit_out 0,1,0,1 in the same cycle as sel.
REQ-025 Change pulse: hold sel=2 for 5 cycles, set sel=3 -> sel_changed=1 for exactly one cycle after the next edge, valid_out=0 that cycle, then 1.
REQ-026 Back-to-back: sel 0->1->2 on consecutive edges -> sel_changed high for 2 consecutive cycles, then 0.
REQ-027 Reset priming: rst high with sel=3, release -> no sel_changed pulse on any edge; assert rst mid-pulse -> sel_changed drops to 0 at once, alt_bit returns to ALT_INIT.
